// File: rtl/cat_pkg.sv
// ---------------------------------------------------------------------------
// cat_pkg
// Shared definitions for the chromatic-adaptation frame sequencer:
//   ONE          - Q16.16 representation of 1.0
//   IDENTITY_MTX - 3x3 identity matrix, 9x Q16.16, row-major, m00 at [31:0]
//   state_e      - sequencer FSM states
//   mtx_elem     - extract element (row, col) from a packed 288-bit matrix
// ---------------------------------------------------------------------------
package cat_pkg;

  localparam logic [31:0] ONE = 32'h0001_0000;

  // Element order from MSB down: m22 m21 m20 m12 m11 m10 m02 m01 m00
  localparam logic [287:0] IDENTITY_MTX = {
    ONE,   32'h0, 32'h0,
    32'h0, ONE,   32'h0,
    32'h0, 32'h0, ONE
  };

  typedef enum logic [2:0] {
    IDLE,
    REQ_MTX,
    WAIT_MTX,
    ISSUE,
    WAIT_PIX,
    DRAIN
  } state_e;

  function automatic logic [31:0] mtx_elem(input logic [287:0] m,
                                           input int unsigned row,
                                           input int unsigned col);
    logic [8:0] base;
    base = 9'((row * 3 + col) * 32);
    return m[base +: 32];
  endfunction

endpackage

// File: rtl/cat_skid_reg.sv
// ---------------------------------------------------------------------------
// cat_skid_reg
// Single-entry output register between image_processor and the downstream
// ready/valid sink. The sequencer only loads it while it is empty, so a load
// and a downstream handshake never coincide.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   load                  - write load_rgb/load_last and mark the entry valid
//   load_rgb, load_last   - pixel and end-of-frame flag to store
//   m_ready               - downstream ready; frees the entry on handshake
//   m_rgb, m_valid, m_last- downstream pixel interface
// ---------------------------------------------------------------------------
module cat_skid_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] load_rgb,
  input  logic        load_last,
  input  logic        m_ready,
  output logic [23:0] m_rgb,
  output logic        m_valid,
  output logic        m_last
);

  logic [23:0] rgb_q, rgb_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;

  always_comb begin
    rgb_d   = rgb_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load) begin
      rgb_d   = load_rgb;
      valid_d = 1'b1;
      last_d  = load_last;
    end else if (valid_q && m_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign m_rgb   = rgb_q;
  assign m_valid = valid_q;
  assign m_last  = last_q;

endmodule

// File: rtl/cat_frame_sequencer.sv
// ---------------------------------------------------------------------------
// cat_frame_sequencer
// Frame controller for the chromatic-adaptation datapath. At each frame start
// it fetches a fresh compensation matrix from the Bradford adaptor when the
// ambient sample or the reference CCT changed, latches it for the image
// processor, then streams one frame of RGB888 pixels through the processor
// with exactly one pixel in flight.
//
// Optional feature macro: PIX_TIMEOUT_EN
//   defined   - WAIT_PIX gives up after PIX_TIMEOUT cycles, substitutes
//               24'hFF0000 and raises the sticky pix_err output.
//   undefined - WAIT_PIX waits indefinitely; no pix_err port.
//
// Ports:
//   frame_start, cct_cfg                 - frame trigger and reference CCT
//   amb_xyz, amb_valid                   - ambient XYZ samples (Q16.16)
//   ad_xyz, ad_xyz_valid, ad_ref_cct     - request to the adaptor
//   ad_matrix, ad_matrix_valid           - adaptor response
//   pr_matrix, pr_matrix_valid           - latched matrix for the processor
//   pr_rgb, pr_valid, pr_ready           - pixel into the processor
//   pr_out_rgb, pr_out_valid             - pixel out of the processor
//   s_rgb, s_valid, s_ready              - upstream pixel stream
//   m_rgb, m_valid, m_ready, m_last      - downstream pixel stream
//   frame_done, busy, mtx_err (, pix_err)- status
// ---------------------------------------------------------------------------
module cat_frame_sequencer
  import cat_pkg::*;
#(
  parameter int          IMAGE_WIDTH  = 768,
  parameter int          IMAGE_HEIGHT = 512,
  parameter int          MTX_TIMEOUT  = 2000,
  parameter int          PIX_TIMEOUT  = 1000,
  parameter logic [15:0] CCT_DEFAULT  = 16'd6500
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_start,
  input  logic [95:0]  amb_xyz,
  input  logic         amb_valid,
  input  logic [15:0]  cct_cfg,
  output logic [95:0]  ad_xyz,
  output logic         ad_xyz_valid,
  output logic [15:0]  ad_ref_cct,
  input  logic [287:0] ad_matrix,
  input  logic         ad_matrix_valid,
  output logic [287:0] pr_matrix,
  output logic         pr_matrix_valid,
  output logic [23:0]  pr_rgb,
  output logic         pr_valid,
  input  logic         pr_ready,
  input  logic [23:0]  pr_out_rgb,
  input  logic         pr_out_valid,
  input  logic [23:0]  s_rgb,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [23:0]  m_rgb,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last,
  output logic         frame_done,
  output logic         busy,
  output logic         mtx_err
`ifdef PIX_TIMEOUT_EN
  ,
  output logic         pix_err
`endif
);

  localparam int TOTAL_PIX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int CNT_W     = (TOTAL_PIX > 1) ? $clog2(TOTAL_PIX) : 1;
  localparam int MTX_W     = (MTX_TIMEOUT > 1) ? $clog2(MTX_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL_PIX - 1);
  localparam logic [MTX_W-1:0] MTX_LAST = MTX_W'(MTX_TIMEOUT - 1);

  // Reject degenerate configurations at elaboration time.
  if (TOTAL_PIX < 1 || MTX_TIMEOUT < 1 || PIX_TIMEOUT < 1) begin : g_bad_cfg
    $error("cat_frame_sequencer: dimensions and timeouts must be >= 1");
  end

  state_e         state_q, state_d;
  logic           pend_q, pend_d;
  logic [95:0]    shadow_q, shadow_d;
  logic [95:0]    ad_xyz_q, ad_xyz_d;
  logic           ad_xyz_valid_q, ad_xyz_valid_d;
  logic [15:0]    ad_ref_cct_q, ad_ref_cct_d;
  logic [287:0]   pr_matrix_q, pr_matrix_d;
  logic           pr_matrix_valid_q, pr_matrix_valid_d;
  logic [23:0]    pr_rgb_q, pr_rgb_d;
  logic           pr_valid_q, pr_valid_d;
  logic [MTX_W-1:0] mtx_cnt_q, mtx_cnt_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic           frame_done_q, frame_done_d;
  logic           mtx_err_q, mtx_err_d;

  logic           cap_load;
  logic [23:0]    cap_rgb;
  logic           last_pix;

`ifdef PIX_TIMEOUT_EN
  localparam int PIX_W = (PIX_TIMEOUT > 1) ? $clog2(PIX_TIMEOUT) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_TIMEOUT - 1);
  localparam logic [23:0] PIX_FILL_RGB = 24'hFF0000;
  logic [PIX_W-1:0] pix_to_cnt_q, pix_to_cnt_d;
  logic           pix_err_q, pix_err_d;
`endif

  assign last_pix = (pix_cnt_q == LAST_IDX);
  // Only accept upstream data when the processor can take it and the output
  // register has drained, which keeps exactly one pixel in flight.
  assign s_ready  = (state_q == ISSUE) && pr_ready && !m_valid;

  always_comb begin
    state_d           = state_q;
    pend_d            = pend_q;
    shadow_d          = shadow_q;
    ad_xyz_d          = ad_xyz_q;
    ad_xyz_valid_d    = 1'b0;
    ad_ref_cct_d      = ad_ref_cct_q;
    pr_matrix_d       = pr_matrix_q;
    pr_matrix_valid_d = pr_matrix_valid_q;
    pr_rgb_d          = pr_rgb_q;
    pr_valid_d        = 1'b0;
    mtx_cnt_d         = mtx_cnt_q;
    pix_cnt_d         = pix_cnt_q;
    frame_done_d      = 1'b0;
    mtx_err_d         = mtx_err_q;
    cap_load          = 1'b0;
    cap_rgb           = pr_out_rgb;
`ifdef PIX_TIMEOUT_EN
    pix_to_cnt_d      = pix_to_cnt_q;
    pix_err_d         = pix_err_q;
`endif

    // The shadow updates first so a sample arriving with frame_start counts.
    if (amb_valid) begin
      shadow_d = amb_xyz;
      pend_d   = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          ad_ref_cct_d = cct_cfg;
`ifdef PIX_TIMEOUT_EN
          pix_err_d    = 1'b0;
`endif
          if (pend_d || (cct_cfg != ad_ref_cct_q)) state_d = REQ_MTX;
          else                                     state_d = ISSUE;
        end
      end
      REQ_MTX: begin
        ad_xyz_d          = shadow_d;
        ad_xyz_valid_d    = 1'b1;
        pend_d            = 1'b0;
        mtx_cnt_d         = '0;
        pr_matrix_valid_d = 1'b0;
        state_d           = WAIT_MTX;
      end
      WAIT_MTX: begin
        if (ad_matrix_valid) begin
          pr_matrix_d       = ad_matrix;
          pr_matrix_valid_d = 1'b1;
          mtx_err_d         = 1'b0;
          state_d           = ISSUE;
        end else if (mtx_cnt_q == MTX_LAST) begin
          // Adaptor silent: fall back to a pass-through matrix.
          pr_matrix_d       = IDENTITY_MTX;
          pr_matrix_valid_d = 1'b1;
          mtx_err_d         = 1'b1;
          state_d           = ISSUE;
        end else begin
          mtx_cnt_d = mtx_cnt_q + MTX_W'(1);
        end
      end
      ISSUE: begin
        if (s_valid && s_ready) begin
          pr_rgb_d   = s_rgb;
          pr_valid_d = 1'b1;
`ifdef PIX_TIMEOUT_EN
          pix_to_cnt_d = '0;
`endif
          state_d    = WAIT_PIX;
        end
      end
      WAIT_PIX: begin
        if (pr_out_valid) begin
          cap_load = 1'b1;
          cap_rgb  = pr_out_rgb;
        end
`ifdef PIX_TIMEOUT_EN
        else if (pix_to_cnt_q == PIX_LAST) begin
          cap_load  = 1'b1;
          cap_rgb   = PIX_FILL_RGB;
          pix_err_d = 1'b1;
        end else begin
          pix_to_cnt_d = pix_to_cnt_q + PIX_W'(1);
        end
`endif
        if (cap_load) begin
          // The counter holds on the last pixel so it never wraps mid-frame.
          if (last_pix) begin
            state_d = DRAIN;
          end else begin
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
            state_d   = ISSUE;
          end
        end
      end
      DRAIN: begin
        if (m_valid && m_ready) begin
          frame_done_d = 1'b1;
          pix_cnt_d    = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      pend_q            <= 1'b1;
      shadow_q          <= '0;
      ad_xyz_q          <= '0;
      ad_xyz_valid_q    <= 1'b0;
      ad_ref_cct_q      <= CCT_DEFAULT;
      pr_matrix_q       <= IDENTITY_MTX;
      pr_matrix_valid_q <= 1'b1;
      pr_rgb_q          <= '0;
      pr_valid_q        <= 1'b0;
      mtx_cnt_q         <= '0;
      pix_cnt_q         <= '0;
      frame_done_q      <= 1'b0;
      mtx_err_q         <= 1'b0;
`ifdef PIX_TIMEOUT_EN
      pix_to_cnt_q      <= '0;
      pix_err_q         <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      pend_q            <= pend_d;
      shadow_q          <= shadow_d;
      ad_xyz_q          <= ad_xyz_d;
      ad_xyz_valid_q    <= ad_xyz_valid_d;
      ad_ref_cct_q      <= ad_ref_cct_d;
      pr_matrix_q       <= pr_matrix_d;
      pr_matrix_valid_q <= pr_matrix_valid_d;
      pr_rgb_q          <= pr_rgb_d;
      pr_valid_q        <= pr_valid_d;
      mtx_cnt_q         <= mtx_cnt_d;
      pix_cnt_q         <= pix_cnt_d;
      frame_done_q      <= frame_done_d;
      mtx_err_q         <= mtx_err_d;
`ifdef PIX_TIMEOUT_EN
      pix_to_cnt_q      <= pix_to_cnt_d;
      pix_err_q         <= pix_err_d;
`endif
    end
  end

  cat_skid_reg u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (cap_load),
    .load_rgb  (cap_rgb),
    .load_last (last_pix),
    .m_ready   (m_ready),
    .m_rgb     (m_rgb),
    .m_valid   (m_valid),
    .m_last    (m_last)
  );

  assign ad_xyz          = ad_xyz_q;
  assign ad_xyz_valid    = ad_xyz_valid_q;
  assign ad_ref_cct      = ad_ref_cct_q;
  assign pr_matrix       = pr_matrix_q;
  assign pr_matrix_valid = pr_matrix_valid_q;
  assign pr_rgb          = pr_rgb_q;
  assign pr_valid        = pr_valid_q;
  assign frame_done      = frame_done_q;
  assign mtx_err         = mtx_err_q;
  assign busy            = (state_q != IDLE);
`ifdef PIX_TIMEOUT_EN
  assign pix_err         = pix_err_q;
`endif

endmodule
